// File: rtl/sprite_pkg.sv
// sprite_pkg: shared definitions for the sprite blitter.
//   state_e       - blitter FSM state encoding
//   DEF_SCREEN_W  - default visible screen width
//   DEF_SCREEN_H  - default visible screen height
//   DEF_COLOR_W   - default bits per pixel
//   clog2()       - ceiling log2, never less than 1 so zero-width vectors cannot appear
package sprite_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StDraw  = 2'd1,
        StFlush = 2'd2,
        StDone  = 2'd3
    } state_e;

    localparam int unsigned DEF_SCREEN_W = 320;
    localparam int unsigned DEF_SCREEN_H = 240;
    localparam int unsigned DEF_COLOR_W  = 3;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return (result == 0) ? 1 : result;
    endfunction

endpackage

// File: rtl/sprite_rom.sv
// sprite_rom: single-port sprite pixel store with synchronous read.
// The address is registered and the array output is not, so data for an
// address presented in cycle C appears in cycle C+1.
// Ports:
//   clk     in   system clock
//   i_addr  in   ADDR_W  read address
//   o_q     out  WIDTH   pixel data for the address registered last cycle
module sprite_rom
    import sprite_pkg::*;
#(
    parameter int unsigned DEPTH     = 8192,
    parameter int unsigned WIDTH     = DEF_COLOR_W,
    parameter string       INIT_FILE = "sprites.mif",
    parameter int unsigned ADDR_W    = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [WIDTH-1:0]  o_q
);

    // Contents come from INIT_FILE through the memory-initialisation flow of
    // the target toolchain; the array is never written by the design itself.
    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [ADDR_W-1:0] r_addr;

    always_ff @(posedge clk) begin
        r_addr <= i_addr;
    end

    assign o_q = r_mem[r_addr];

endmodule

// File: rtl/draw_sprite_gen.sv
// draw_sprite_gen: streams one sprite from the sprite ROM to the framebuffer
// write port, one pixel per clock, with flip, colour-key and screen clipping.
// Ports:
//   clk, reset          in   clock, synchronous active-high reset
//   plot                in   start request, sampled only when idle
//   x_pos, y_pos        in   top-left screen position of the sprite
//   sprite_sel          in   sprite index (out-of-range selects sprite 0)
//   flip_x, flip_y      in   horizontal / vertical mirror
//   x, y, color         out  pixel coordinate and colour
//   writeEn             out  x, y, color must be written this cycle
//   busy                out  request in progress
//   draw_done           out  one-cycle completion pulse
module draw_sprite_gen
    import sprite_pkg::*;
#(
    parameter int unsigned SPRITE_W    = 32,
    parameter int unsigned SPRITE_H    = 32,
    parameter int unsigned NUM_SPRITES = 8,
    parameter int unsigned COLOR_W     = DEF_COLOR_W,
    parameter int unsigned COORD_W     = 10,
    parameter int unsigned SCREEN_W    = DEF_SCREEN_W,
    parameter int unsigned SCREEN_H    = DEF_SCREEN_H,
    parameter int unsigned TRANSPARENT = 0,
    parameter string       INIT_FILE   = "sprites.mif"
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          plot,
    input  logic [COORD_W-1:0]            x_pos,
    input  logic [COORD_W-1:0]            y_pos,
    input  logic [clog2(NUM_SPRITES)-1:0] sprite_sel,
    input  logic                          flip_x,
    input  logic                          flip_y,
    output logic [COORD_W-1:0]            x,
    output logic [COORD_W-1:0]            y,
    output logic [COLOR_W-1:0]            color,
    output logic                          writeEn,
    output logic                          busy,
    output logic                          draw_done
);

    localparam int unsigned SEL_W  = clog2(NUM_SPRITES);
    localparam int unsigned COL_W  = clog2(SPRITE_W);
    localparam int unsigned ROW_W  = clog2(SPRITE_H);
    localparam int unsigned PIX_N  = SPRITE_W * SPRITE_H;
    localparam int unsigned DEPTH  = NUM_SPRITES * PIX_N;
    localparam int unsigned ADDR_W = clog2(DEPTH);
    localparam int unsigned EXT_W  = COORD_W + 1;

    state_e             r_state;
    state_e             w_state_next;
    logic               w_issue;

    logic [COORD_W-1:0] r_x_org;
    logic [COORD_W-1:0] r_y_org;
    logic [SEL_W-1:0]   r_sel;
    logic               r_flip_x;
    logic               r_flip_y;
    logic [COL_W-1:0]   r_col;
    logic [ROW_W-1:0]   r_row;

    logic               w_accept;
    logic               w_col_last;
    logic               w_last;
    logic [SEL_W-1:0]   w_sel_eff;
    logic [COL_W-1:0]   w_scol;
    logic [ROW_W-1:0]   w_srow;
    logic [ADDR_W-1:0]  w_addr;
    logic [COLOR_W-1:0] w_q;

    logic [EXT_W-1:0]   w_sx;
    logic [EXT_W-1:0]   w_sy;
    logic               w_clip;
    logic               r_valid;
    logic               r_clip;
    logic [COORD_W-1:0] r_x;
    logic [COORD_W-1:0] r_y;

    assign w_accept   = (r_state == StIdle) && plot;
    assign w_col_last = (r_col == COL_W'(SPRITE_W - 1));
    assign w_last     = w_col_last && (r_row == ROW_W'(SPRITE_H - 1));
    assign w_sel_eff  = (32'(sprite_sel) >= NUM_SPRITES) ? '0 : sprite_sel;

    // FSM: state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM: next state
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (plot) w_state_next = StDraw;
            StDraw:  if (w_last) w_state_next = StFlush;
            StFlush: w_state_next = StDone;
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // FSM: outputs
    always_comb begin
        w_issue   = 1'b0;
        busy      = 1'b0;
        draw_done = 1'b0;
        unique case (r_state)
            StIdle:  ;
            StDraw:  begin w_issue = 1'b1; busy = 1'b1; end
            StFlush: busy = 1'b1;
            StDone:  begin busy = 1'b1; draw_done = 1'b1; end
            default: ;
        endcase
    end

    // Request latch and row-major col/row counters
    always_ff @(posedge clk) begin
        if (reset) begin
            r_x_org  <= '0;
            r_y_org  <= '0;
            r_sel    <= '0;
            r_flip_x <= 1'b0;
            r_flip_y <= 1'b0;
            r_col    <= '0;
            r_row    <= '0;
        end else if (w_accept) begin
            r_x_org  <= x_pos;
            r_y_org  <= y_pos;
            r_sel    <= w_sel_eff;
            r_flip_x <= flip_x;
            r_flip_y <= flip_y;
            r_col    <= '0;
            r_row    <= '0;
        end else if (w_issue) begin
            if (w_col_last) begin
                r_col <= '0;
                r_row <= r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    // Flipping only changes which ROM word is read; screen position still
    // advances with the unflipped col/row.
    assign w_scol = r_flip_x ? (COL_W'(SPRITE_W - 1) - r_col) : r_col;
    assign w_srow = r_flip_y ? (ROW_W'(SPRITE_H - 1) - r_row) : r_row;
    assign w_addr = ADDR_W'(r_sel) * ADDR_W'(PIX_N)
                  + ADDR_W'(w_srow) * ADDR_W'(SPRITE_W)
                  + ADDR_W'(w_scol);

    sprite_rom #(
        .DEPTH     (DEPTH),
        .WIDTH     (COLOR_W),
        .INIT_FILE (INIT_FILE),
        .ADDR_W    (ADDR_W)
    ) u_rom (
        .clk    (clk),
        .i_addr (w_addr),
        .o_q    (w_q)
    );

    // One extra bit so a position past the top of the coordinate range is
    // clipped instead of wrapping onto the left/top of the screen.
    assign w_sx   = EXT_W'(r_x_org) + EXT_W'(r_col);
    assign w_sy   = EXT_W'(r_y_org) + EXT_W'(r_row);
    assign w_clip = (w_sx >= EXT_W'(SCREEN_W)) || (w_sy >= EXT_W'(SCREEN_H));

    // Stage 1: aligned with the ROM read latency
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_clip  <= 1'b0;
            r_x     <= '0;
            r_y     <= '0;
        end else begin
            r_valid <= w_issue;
            if (w_issue) begin
                r_clip <= w_clip;
                r_x    <= w_sx[COORD_W-1:0];
                r_y    <= w_sy[COORD_W-1:0];
            end
        end
    end

    assign x       = r_x;
    assign y       = r_y;
    // Gated so the colour bus reads zero whenever no pixel is being presented
    assign color   = r_valid ? w_q : '0;
    assign writeEn = r_valid && !r_clip && (w_q != COLOR_W'(TRANSPARENT));

endmodule

// File: tb/tb_draw_sprite_gen.sv
// Testbench for draw_sprite_gen with default parameters (32x32, 8 sprites,
// 3-bit colour, 320x240 screen, colour key 0). Stimulus pushes expected
// pixels and draw_done cycles into queues; a negedge monitor pops and compares.
module tb_draw_sprite_gen;

    localparam int N = 1024;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       plot = 1'b0;
    logic [9:0] x_pos = '0;
    logic [9:0] y_pos = '0;
    logic [2:0] sprite_sel = '0;
    logic       flip_x = 1'b0;
    logic       flip_y = 1'b0;
    logic [9:0] x;
    logic [9:0] y;
    logic [2:0] color;
    logic       writeEn;
    logic       busy;
    logic       draw_done;

    draw_sprite_gen dut (
        .clk        (clk),
        .reset      (reset),
        .plot       (plot),
        .x_pos      (x_pos),
        .y_pos      (y_pos),
        .sprite_sel (sprite_sel),
        .flip_x     (flip_x),
        .flip_y     (flip_y),
        .x          (x),
        .y          (y),
        .color      (color),
        .writeEn    (writeEn),
        .busy       (busy),
        .draw_done  (draw_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int rom_m [8192];
    int exp_q [$];
    int done_q [$];
    int n_cmp = 0;
    int n_bad = 0;
    int wcount = 0;
    int first_w = -1;
    int last_w = -1;
    int mon_got;
    int mon_exp;

    function automatic int pack(input int px, input int py, input int pc);
        return (px << 13) | (py << 3) | pc;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (writeEn && draw_done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL overlap: writeEn and draw_done both high at cycle %0d", cyc);
        end
        if (writeEn) begin
            mon_got = pack(int'(x), int'(y), int'(color));
            wcount++;
            if (first_w < 0) first_w = mon_got;
            last_w = mon_got;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL pixel: unexpected write x=%0d y=%0d c=%0d at cycle %0d",
                         x, y, color, cyc);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_got != mon_exp) begin
                    n_bad++;
                    $display("FAIL pixel: got x=%0d y=%0d c=%0d, expected x=%0d y=%0d c=%0d",
                             x, y, color, mon_exp >> 13, (mon_exp >> 3) & 1023, mon_exp & 7);
                end
            end
        end
        if (draw_done) begin
            n_cmp++;
            if (done_q.size() == 0) begin
                n_bad++;
                $display("FAIL draw_done: unexpected pulse at cycle %0d", cyc);
            end else begin
                mon_exp = done_q.pop_front();
                if (cyc != mon_exp) begin
                    n_bad++;
                    $display("FAIL draw_done: at cycle %0d, expected cycle %0d", cyc, mon_exp);
                end
            end
        end
    end

    // mode 0: all 5; mode 1: address mod 8; mode 2: sprite 4 checkerboard of 0/6, rest 5
    task automatic fill(input int mode);
        for (int i = 0; i < 8192; i++) begin
            int v;
            case (mode)
                0: v = 5;
                1: v = i % 8;
                default: v = (i / N == 4) ? ((((i % N) / 32 + i % 32) % 2 != 0) ? 6 : 0) : 5;
            endcase
            rom_m[i] = v;
            dut.u_rom.r_mem[i] = 3'(v);
        end
    endtask

    task automatic push_model(input int xo, input int yo, input int sel,
                              input bit fx, input bit fy, input int npix);
        for (int k = 0; k < npix; k++) begin
            int col, row, sc, sr, c, sx, sy;
            col = k % 32;
            row = k / 32;
            sc  = fx ? 31 - col : col;
            sr  = fy ? 31 - row : row;
            c   = rom_m[sel * N + sr * 32 + sc];
            sx  = xo + col;
            sy  = yo + row;
            if (sx < 320 && sy < 240 && c != 0) exp_q.push_back(pack(sx, sy, c));
        end
    endtask

    // plot_at > 0: extra plot pulse at T+plot_at; abort_at > 0: reset at T+abort_at
    task automatic run_draw(input string tag, input int xo, input int yo, input int sel,
                            input bit fx, input bit fy, input int plot_at, input int abort_at,
                            input int exp_writes);
        int t;
        wcount  = 0;
        first_w = -1;
        last_w  = -1;
        push_model(xo, yo, sel, fx, fy, (abort_at > 0) ? abort_at - 1 : N);
        x_pos      = 10'(xo);
        y_pos      = 10'(yo);
        sprite_sel = 3'(sel);
        flip_x     = fx;
        flip_y     = fy;
        plot       = 1'b1;
        t          = cyc;
        if (abort_at == 0) done_q.push_back(t + N + 2);
        @(posedge clk);
        #1;
        plot       = 1'b0;
        x_pos      = '0;
        y_pos      = '0;
        sprite_sel = ~sprite_sel;
        flip_x     = ~fx;
        flip_y     = ~fy;
        check({tag, "_busy_start"}, int'(busy), 1);
        while (cyc < t + N + 6) begin
            @(posedge clk);
            #1;
            plot = (plot_at > 0 && cyc == t + plot_at);
            if (abort_at > 0) begin
                if (cyc == t + abort_at) begin
                    reset = 1'b1;
                end else if (cyc == t + abort_at + 1) begin
                    check({tag, "_we_after_reset"}, int'(writeEn), 0);
                    check({tag, "_busy_after_reset"}, int'(busy), 0);
                end else if (cyc == t + abort_at + 3) begin
                    reset = 1'b0;
                end
            end else begin
                if (cyc == t + N + 2) check({tag, "_busy_last"}, int'(busy), 1);
                if (cyc == t + N + 3) check({tag, "_busy_end"}, int'(busy), 0);
            end
        end
        check({tag, "_pixels_left"}, exp_q.size(), 0);
        check({tag, "_done_left"}, done_q.size(), 0);
        check({tag, "_write_count"}, wcount, exp_writes);
        exp_q.delete();
        done_q.delete();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_x", int'(x), 0);
        check("reset_y", int'(y), 0);
        check("reset_color", int'(color), 0);
        check("reset_writeEn", int'(writeEn), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_draw_done", int'(draw_done), 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        fill(0);
        run_draw("solid", 10, 20, 0, 1'b0, 1'b0, 100, 0, 1024);
        check("solid_first", first_w, pack(10, 20, 5));
        check("solid_last", last_w, pack(41, 51, 5));

        fill(1);
        run_draw("flipx", 50, 60, 2, 1'b1, 1'b0, 0, 0, 896);
        check("flipx_first", first_w, pack(50, 60, 7));
        run_draw("flipxy", 100, 100, 1, 1'b1, 1'b1, 0, 0, 896);
        check("flipxy_first", first_w, pack(100, 100, 7));

        fill(0);
        run_draw("clip", 300, 230, 0, 1'b0, 1'b0, 0, 0, 200);
        check("clip_first", first_w, pack(300, 230, 5));
        check("clip_last", last_w, pack(319, 239, 5));

        fill(2);
        run_draw("checker", 0, 0, 4, 1'b0, 1'b0, 0, 0, 512);
        check("checker_first", first_w, pack(1, 0, 6));

        run_draw("abort", 10, 20, 0, 1'b0, 1'b0, 0, 500, 499);
        run_draw("after_reset", 5, 5, 0, 1'b0, 1'b0, 0, 0, 1024);
        check("after_reset_last", last_w, pack(36, 36, 5));

        run_draw("wrap", 1020, 0, 0, 1'b0, 1'b0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
